// File: rtl/uart_tx_feeder.sv
// Byte FIFO and send sequencer feeding the UART transmitter, using tx_busy as flow control.
// Optional REQ timeout: define UART_FEEDER_TIMEOUT_EN.
`timescale 1ns/1ps
module uart_tx_feeder #(
    parameter int DEPTH          = 8,
    parameter int ADDR_W         = 3,
    parameter int TIMEOUT_CYCLES = 1000
) (
    input  logic              sys_clk,
    input  logic              reset,
    input  logic [7:0]        wr_data,
    input  logic              wr_valid,
    output logic              wr_ready,
    output logic [ADDR_W:0]   fifo_count,
    output logic              fifo_empty,
    output logic              fifo_full,
    output logic              overflow,
    input  logic              tx_busy,
    output logic [7:0]        tx_data_in,
    output logic              send_data,
    output logic              tx_timeout
);
    typedef enum logic [1:0] {IDLE, LOAD, REQ, WAIT_DONE} state_t;

    state_t            state_q, state_d;
    logic [7:0]        mem_q [DEPTH];
    logic [ADDR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [ADDR_W:0]   count_q, count_d;
    logic [7:0]        tx_data_q, tx_data_d;
    logic              send_q, send_d;
    logic              overflow_q;
    logic              push, pop, tmo_hit;

    assign fifo_full  = (count_q == (ADDR_W+1)'(DEPTH));
    assign fifo_empty = (count_q == '0);
    assign wr_ready   = !fifo_full;
    assign fifo_count = count_q;
    assign overflow   = overflow_q;
    assign tx_data_in = tx_data_q;
    assign send_data  = send_q;
    assign push       = wr_valid && wr_ready;

    // Storage needs no reset; validity is tracked entirely by the pointers and count.
    always_ff @(posedge sys_clk) begin
        if (push) mem_q[wr_ptr_q] <= wr_data;
    end

    always_comb begin
        count_d = count_q;
        if (push && !pop)      count_d = count_q + 1'b1;
        else if (pop && !push) count_d = count_q - 1'b1;
    end

    always_ff @(posedge sys_clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            count_q    <= count_d;
            overflow_q <= overflow_q | (wr_valid && fifo_full);
        end
    end

    // Data is captured on entering LOAD so it is settled a full cycle before send_data rises.
    always_comb begin
        state_d   = state_q;
        tx_data_d = tx_data_q;
        send_d    = send_q;
        pop       = 1'b0;
        case (state_q)
            IDLE: begin
                if (!fifo_empty && !tx_busy) begin
                    state_d   = LOAD;
                    tx_data_d = mem_q[rd_ptr_q];
                end
            end
            LOAD: begin
                state_d = REQ;
                send_d  = 1'b1;
            end
            REQ: begin
                if (tx_busy) begin
                    pop     = 1'b1;
                    send_d  = 1'b0;
                    state_d = WAIT_DONE;
                end else if (tmo_hit) begin
                    send_d  = 1'b0;
                    state_d = IDLE;
                end
            end
            WAIT_DONE: begin
                send_d = 1'b0;
                if (!tx_busy) state_d = IDLE;
            end
            default: begin
                send_d  = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge sys_clk or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            tx_data_q <= 8'h00;
            send_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            tx_data_q <= tx_data_d;
            send_q    <= send_d;
        end
    end

`ifdef UART_FEEDER_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [TMO_W-1:0] tmo_cnt_q, tmo_cnt_d;
    logic             tx_timeout_q;

    // Counter is zero outside REQ, so it is already clear on REQ entry.
    assign tmo_hit    = (tmo_cnt_q == TMO_W'(TIMEOUT_CYCLES - 1));
    assign tx_timeout = tx_timeout_q;

    always_comb begin
        tmo_cnt_d = '0;
        if (state_q == REQ && !tx_busy && !tmo_hit) tmo_cnt_d = tmo_cnt_q + TMO_W'(1);
    end

    always_ff @(posedge sys_clk or negedge reset) begin
        if (!reset) begin
            tmo_cnt_q    <= '0;
            tx_timeout_q <= 1'b0;
        end else begin
            tmo_cnt_q    <= tmo_cnt_d;
            tx_timeout_q <= tx_timeout_q | (state_q == REQ && !tx_busy && tmo_hit);
        end
    end
`else
    assign tmo_hit    = 1'b0;
    assign tx_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_uart_tx_feeder.sv
// Bench for uart_tx_feeder: behavioural UART busy model plus a queue-based FIFO reference.
`timescale 1ns/1ps
module tb_uart_tx_feeder;
    localparam int DEPTH = 8;

    logic       sys_clk = 1'b0;
    logic       reset   = 1'b1;
    logic [7:0] wr_data = 8'h00;
    logic       wr_valid = 1'b0;
    logic       wr_ready, fifo_empty, fifo_full, overflow;
    logic [3:0] fifo_count;
    logic       tx_busy, send_data, tx_timeout;
    logic [7:0] tx_data_in;

    // UART model state
    logic model_busy = 1'b0, hold_busy = 1'b0, model_en = 1'b0, model_act = 1'b0;
    int   busy_len = 0, mlen = 0;

    // Reference model: accepted bytes in order, bytes taken by the UART in order
    logic [7:0] ref_q[$], got_q[$];
    int   acc = 0, pop_cnt = 0;
    logic exp_ovf = 1'b0;

    int n_assert = 0, n_fail = 0;

    assign tx_busy = model_busy | hold_busy;
    always #10 sys_clk = ~sys_clk;

    uart_tx_feeder dut (
        .sys_clk    (sys_clk),
        .reset      (reset),
        .wr_data    (wr_data),
        .wr_valid   (wr_valid),
        .wr_ready   (wr_ready),
        .fifo_count (fifo_count),
        .fifo_empty (fifo_empty),
        .fifo_full  (fifo_full),
        .overflow   (overflow),
        .tx_busy    (tx_busy),
        .tx_data_in (tx_data_in),
        .send_data  (send_data),
        .tx_timeout (tx_timeout)
    );

    // UART: sees send_data, raises busy on the following cycle, latches the byte, stays busy mlen cycles.
    initial begin
        forever begin
            @(posedge sys_clk); #2;
            if (model_en && send_data && !model_busy) begin
                model_act = 1'b1;
                mlen = (busy_len == 0) ? int'($urandom_range(1, 6)) : busy_len;
                @(posedge sys_clk); #2;
                model_busy = 1'b1;
                got_q.push_back(tx_data_in);
                pop_cnt++;
                repeat (mlen) @(posedge sys_clk);
                #2 model_busy = 1'b0;
                model_act = 1'b0;
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock: optionally offer a byte, then compare occupancy against the reference.
    task automatic cycle(input logic v, input logic [7:0] d);
        int pre, cnt;
        pre = acc - pop_cnt;
        wr_valid = v;
        wr_data  = d;
        @(posedge sys_clk); #1;
        wr_valid = 1'b0;
        if (v) begin
            if (pre < DEPTH) begin
                ref_q.push_back(d);
                acc++;
            end else begin
                exp_ovf = 1'b1;
            end
        end
        cnt = acc - pop_cnt;
        chk("count", fifo_count, cnt);
        chk("empty", fifo_empty, cnt == 0);
        chk("ready", wr_ready, cnt != DEPTH);
        chk("overflow", overflow, exp_ovf);
    endtask

    task automatic drain(input int budget);
        int n;
        n = 0;
        while ((acc != pop_cnt || model_act) && n < budget) begin
            cycle(1'b0, 8'h00);
            n++;
        end
        chk("drain_bound", n < budget, 1);
        chk("drain_size", got_q.size(), ref_q.size());
        for (int i = 0; i < got_q.size() && i < ref_q.size(); i++)
            chk("order", got_q[i], ref_q[i]);
    endtask

    task automatic clear_model();
        acc = 0;
        pop_cnt = 0;
        exp_ovf = 1'b0;
        ref_q.delete();
        got_q.delete();
    endtask

    initial begin
        int n;
        logic [7:0] b;

        // Reset state
        #3 reset = 1'b0;
        #2;
        chk("rst_ready", wr_ready, 1);
        chk("rst_empty", fifo_empty, 1);
        chk("rst_full", fifo_full, 0);
        chk("rst_count", fifo_count, 0);
        chk("rst_txdata", tx_data_in, 8'h00);
        chk("rst_send", send_data, 0);
        chk("rst_ovf", overflow, 0);
        chk("rst_tmo", tx_timeout, 0);
        repeat (2) @(negedge sys_clk);
        reset = 1'b1;
        @(posedge sys_clk); #1;

        // Single byte latency: send_data on the third edge counting the write edge
        model_en = 1'b1;
        busy_len = 100;
        cycle(1'b1, 8'hA5);
        chk("lat_w", send_data, 0);
        cycle(1'b0, 8'h00);
        chk("lat_load", send_data, 0);
        cycle(1'b0, 8'h00);
        chk("lat_req", send_data, 1);
        chk("lat_data", tx_data_in, 8'hA5);
        cycle(1'b0, 8'h00);
        chk("lat_hold", send_data, 1);
        cycle(1'b0, 8'h00);
        chk("pop_send", send_data, 0);
        chk("pop_empty", fifo_empty, 1);
        drain(300);

        // Burst into a full FIFO while the UART is busy elsewhere
        busy_len = 0;
        hold_busy = 1'b1;
        for (int i = 1; i <= 8; i++) cycle(1'b1, 8'(i));
        chk("full_ready", wr_ready, 0);
        chk("full_flag", fifo_full, 1);
        chk("full_send", send_data, 0);
        cycle(1'b1, 8'h09);
        chk("ovf_set", overflow, 1);
        hold_busy = 1'b0;
        drain(500);
        chk("burst_last", got_q[got_q.size()-1], 8'h08);

        // Random traffic: concurrent write/pop, pointer wrap, overflow under load
        for (int i = 0; i < 150; i++) begin
            b = 8'($urandom);
            cycle(1'($urandom_range(0, 1)), b);
        end
        drain(2000);

`ifdef UART_FEEDER_TIMEOUT_EN
        // UART never answers: REQ gives up after TIMEOUT_CYCLES and retries the same byte
        model_en = 1'b0;
        cycle(1'b1, 8'h5A);
        n = 0;
        while (!send_data && n < 10) begin cycle(1'b0, 8'h00); n++; end
        chk("tmo_req", send_data, 1);
        n = 0;
        while (send_data && n < 1100) begin cycle(1'b0, 8'h00); n++; end
        chk("tmo_len", n, 1000);
        chk("tmo_flag", tx_timeout, 1);
        n = 0;
        while (!send_data && n < 10) begin cycle(1'b0, 8'h00); n++; end
        chk("tmo_retry", send_data, 1);
        chk("tmo_data", tx_data_in, 8'h5A);
        reset = 1'b0;
        #1;
        chk("tmo_rst", tx_timeout, 0);
        clear_model();
        @(negedge sys_clk);
        reset = 1'b1;
        @(posedge sys_clk); #1;
`endif

        // Reset while a byte is being requested and four are queued
        model_en = 1'b0;
        for (int i = 0; i < 4; i++) begin
            b = 8'($urandom);
            cycle(1'b1, b);
        end
        cycle(1'b0, 8'h00);
        chk("mid_req", send_data, 1);
        reset = 1'b0;
        #1;
        chk("mid_send", send_data, 0);
        chk("mid_count", fifo_count, 0);
        chk("mid_empty", fifo_empty, 1);
        chk("mid_ovf", overflow, 0);
        chk("mid_txdata", tx_data_in, 8'h00);
        clear_model();
        @(negedge sys_clk);
        reset = 1'b1;
        @(posedge sys_clk); #1;
        n = 0;
        for (int i = 0; i < 6; i++) begin
            cycle(1'b0, 8'h00);
            if (send_data) n++;
        end
        chk("mid_quiet", n, 0);
        model_en = 1'b1;
        busy_len = 3;
        cycle(1'b1, 8'hC3);
        drain(100);
`ifndef UART_FEEDER_TIMEOUT_EN
        chk("tmo_tied", tx_timeout, 0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end
endmodule
